// File: rtl/tm_shiftreg_pkg.sv
// Shared definitions for the TMIIa configuration shift-register controllers.
package tm_shiftreg_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      LOAD     = 2'd3
   } sr_state_t;

   // Ceiling log2, usable in parameter and localparam expressions.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/tm_sr_tick.sv
// Phase timer: a DIV-cycle down-counter with terminal-count tick.
// Reused back to back for the low, high and load phases of the serial engine.
module tm_sr_tick
   import tm_shiftreg_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int            PW     = clog2(DIV + 1);
   localparam logic [PW-1:0] RELOAD = PW'(DIV - 1);

   logic [PW-1:0] cnt;

   // Reload on restart, otherwise count down and park at the terminal count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= RELOAD;
      end else if (restart) begin
         cnt <= RELOAD;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/tm_shiftreg_ctrl.sv
// Serial engine that writes and reads back the TMIIa configuration shift
// register: WIDTH bits out MSB first on sr_din, WIDTH bits in from sr_dout,
// then a DIV-cycle sr_load strobe and a one-cycle done pulse.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | waiting for start; sr_clk, sr_load low
//   SHIFT_LO | sr_clk low for DIV cycles, sr_din holds the current bit
//   SHIFT_HI | sr_clk high for DIV cycles; sr_dout captured at the end
//   LOAD     | sr_load high for DIV cycles, then done and back to IDLE
module tm_shiftreg_ctrl
   import tm_shiftreg_pkg::*;
#(
   parameter int WIDTH = 130,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] data_out,
   output logic             sr_clk,
   output logic             sr_din,
   output logic             sr_load,
   input  logic             sr_dout
);

   localparam int            BW       = clog2(WIDTH + 1);
   localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

   sr_state_t        state;
   logic [WIDTH-1:0] tx_reg;
   logic [WIDTH-1:0] rx_reg;
   logic [BW-1:0]    bit_cnt;
   logic             tick;
   logic             restart;

   // The phase timer is held in reload while idle and reloaded at every phase
   // boundary, so each phase starts with a full DIV-cycle count.
   assign restart = (state == IDLE) || tick;

   tm_sr_tick #(
      .DIV(DIV)
   ) u_tick (
      .clk(clk),
      .rst(rst),
      .restart(restart),
      .tick(tick)
   );

   // Transfer sequencer with registered serial and handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         tx_reg   <= '0;
         rx_reg   <= '0;
         bit_cnt  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         data_out <= '0;
         sr_clk   <= 1'b0;
         sr_din   <= 1'b0;
         sr_load  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  tx_reg  <= data_in;
                  sr_din  <= data_in[WIDTH-1];
                  bit_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= SHIFT_LO;
               end
            end
            SHIFT_LO: begin
               if (tick) begin
                  sr_clk <= 1'b1;
                  state  <= SHIFT_HI;
               end
            end
            SHIFT_HI: begin
               if (tick) begin
                  rx_reg  <= {rx_reg[WIDTH-2:0], sr_dout};
                  tx_reg  <= {tx_reg[WIDTH-2:0], 1'b0};
                  sr_clk  <= 1'b0;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_IDX) begin
                     sr_load <= 1'b1;
                     sr_din  <= 1'b0;
                     state   <= LOAD;
                  end else begin
                     // sr_din moves only on the falling sr_clk edge.
                     sr_din <= tx_reg[WIDTH-2];
                     state  <= SHIFT_LO;
                  end
               end
            end
            LOAD: begin
               if (tick) begin
                  sr_load  <= 1'b0;
                  data_out <= rx_reg;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tm_shiftreg_ctrl.sv
// Bench for tm_shiftreg_ctrl: three instances (8b/DIV2, 8b/DIV1, default
// 130b/DIV4) driven by directed and random transfers, checked against a
// bench-side chip model and transfer-level timing rules.
module tb_tm_shiftreg_ctrl;

   localparam int N = 3;

   logic         clk;
   logic         rst;
   logic         start_v   [N];
   logic [129:0] din_v     [N];
   logic         busy_v    [N];
   logic         done_v    [N];
   logic         sclk_v    [N];
   logic         sdin_v    [N];
   logic         sload_v   [N];
   logic         sdout_v   [N];
   logic [7:0]   dout_a;
   logic [7:0]   dout_b;
   logic [129:0] dout_c;
   logic [129:0] dout_v    [N];

   // sr_dout source per instance: 0 chip model, 1 loopback of sr_din, 2 tied high
   int           mode_v    [N];
   logic [129:0] pre_v     [N];

   logic [129:0] chip_v    [N];
   logic [129:0] rec_v     [N];
   logic         prev_sclk_v [N];
   logic         prev_done_v [N];
   logic         din_s_v   [N];
   int           rises_v   [N];
   int           done_cnt_v [N];
   int           busy_cnt_v [N];
   int           load_cnt_v [N];
   int           done_last_v [N];
   int           first_rise_v [N];
   int           last_fall_v [N];
   int           e0_v      [N];

   int cyc;
   int n_tests;
   int n_fail;

   function automatic int w_of(input int i);
      return (i == 2) ? 130 : 8;
   endfunction

   function automatic int d_of(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
   endfunction

   function automatic int lat_of(input int i);
      return 2 * d_of(i) * w_of(i) + d_of(i);
   endfunction

   function automatic logic [129:0] mask_of(input int i);
      return (w_of(i) == 130) ? {130{1'b1}} : ((130'd1 << w_of(i)) - 130'd1);
   endfunction

   function automatic logic [129:0] rand130();
      logic [159:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[129:0];
   endfunction

   task automatic check_val(input string tag, input logic [129:0] got, input logic [129:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   tm_shiftreg_ctrl #(.WIDTH(8), .DIV(2)) u_dut_w8d2 (
      .clk(clk), .rst(rst), .start(start_v[0]), .data_in(din_v[0][7:0]),
      .busy(busy_v[0]), .done(done_v[0]), .data_out(dout_a),
      .sr_clk(sclk_v[0]), .sr_din(sdin_v[0]), .sr_load(sload_v[0]), .sr_dout(sdout_v[0])
   );

   tm_shiftreg_ctrl #(.WIDTH(8), .DIV(1)) u_dut_w8d1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .data_in(din_v[1][7:0]),
      .busy(busy_v[1]), .done(done_v[1]), .data_out(dout_b),
      .sr_clk(sclk_v[1]), .sr_din(sdin_v[1]), .sr_load(sload_v[1]), .sr_dout(sdout_v[1])
   );

   tm_shiftreg_ctrl u_dut_dflt (
      .clk(clk), .rst(rst), .start(start_v[2]), .data_in(din_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .data_out(dout_c),
      .sr_clk(sclk_v[2]), .sr_din(sdin_v[2]), .sr_load(sload_v[2]), .sr_dout(sdout_v[2])
   );

   assign dout_v[0] = {122'd0, dout_a};
   assign dout_v[1] = {122'd0, dout_b};
   assign dout_v[2] = dout_c;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Serial source seen by each DUT.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         case (mode_v[i])
            1:       sdout_v[i] = sdin_v[i];
            2:       sdout_v[i] = 1'b1;
            default: sdout_v[i] = chip_v[i][w_of(i)-1];
         endcase
      end
   end

   // Chip model (samples sr_din on the sr_clk rise, shifts on the fall so its
   // MSB is stable when the controller captures) plus transfer statistics.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         prev_sclk_v[i] <= sclk_v[i];
         prev_done_v[i] <= done_v[i];
         if (!prev_sclk_v[i] && sclk_v[i]) begin
            if (rises_v[i] == 0) first_rise_v[i] <= cyc;
            rises_v[i] <= rises_v[i] + 1;
            rec_v[i]   <= {rec_v[i][128:0], sdin_v[i]};
            din_s_v[i] <= sdin_v[i];
         end
         if (prev_sclk_v[i] && sclk_v[i])
            check_val($sformatf("sr_din_stable_%0d", i), 130'(sdin_v[i]), 130'(din_s_v[i]));
         if (prev_sclk_v[i] && !sclk_v[i]) begin
            chip_v[i]      <= ((chip_v[i] << 1) | 130'(din_s_v[i])) & mask_of(i);
            last_fall_v[i] <= cyc;
         end
         if (busy_v[i])  busy_cnt_v[i] <= busy_cnt_v[i] + 1;
         if (sload_v[i]) load_cnt_v[i] <= load_cnt_v[i] + 1;
         if (done_v[i]) begin
            check_val($sformatf("done_single_%0d", i), 130'(prev_done_v[i]), 130'(0));
            done_cnt_v[i]  <= done_cnt_v[i] + 1;
            done_last_v[i] <= cyc;
         end
         if (start_v[i] && !busy_v[i] && !rst) begin
            chip_v[i]     <= pre_v[i] & mask_of(i);
            rises_v[i]    <= 0;
            rec_v[i]      <= '0;
            busy_cnt_v[i] <= 0;
            load_cnt_v[i] <= 0;
            done_cnt_v[i] <= 0;
         end
      end
   end

   task automatic launch(input int i, input logic [129:0] word);
      @(posedge clk); #1;
      din_v[i]   = word;
      start_v[i] = 1'b1;
      @(posedge clk); #1;
      start_v[i] = 1'b0;
      din_v[i]   = rand130();
      e0_v[i]    = cyc;
   endtask

   task automatic wait_done(input int i, output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      while (n < 3000 && !ok) begin
         @(posedge clk); #1;
         if (done_v[i]) ok = 1'b1;
         n++;
      end
      if (!ok) check_val($sformatf("done_timeout_%0d", i), 130'(0), 130'(1));
   endtask

   task automatic finish_xfer(input int i, input logic [129:0] word, input logic [129:0] exp_out);
      bit           ok;
      logic [129:0] m;
      m = mask_of(i);
      wait_done(i, ok);
      @(posedge clk); #1;
      if (ok) begin
         check_val($sformatf("latency_%0d", i), 130'(done_last_v[i] - e0_v[i]), 130'(lat_of(i)));
         check_val($sformatf("done_count_%0d", i), 130'(done_cnt_v[i]), 130'(1));
         check_val($sformatf("busy_cycles_%0d", i), 130'(busy_cnt_v[i]), 130'(lat_of(i)));
         check_val($sformatf("load_cycles_%0d", i), 130'(load_cnt_v[i]), 130'(d_of(i)));
         check_val($sformatf("clk_rises_%0d", i), 130'(rises_v[i]), 130'(w_of(i)));
         check_val($sformatf("clk_span_%0d", i), 130'(last_fall_v[i] - first_rise_v[i]),
                   130'((2 * w_of(i) - 1) * d_of(i)));
         check_val($sformatf("din_order_%0d", i), rec_v[i] & m, word & m);
         check_val($sformatf("data_out_%0d", i), dout_v[i], exp_out & m);
         check_val($sformatf("done_low_%0d", i), 130'(done_v[i]), 130'(0));
         check_val($sformatf("busy_low_%0d", i), 130'(busy_v[i]), 130'(0));
         if (mode_v[i] == 0)
            check_val($sformatf("chip_reg_%0d", i), chip_v[i], word & m);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [129:0] w;
      logic [129:0] w2;
      logic [129:0] p2;
      bit           ok;
      int           t1;
      int           n;

      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         start_v[i] = 1'b0;
         din_v[i]   = '0;
         mode_v[i]  = 0;
         pre_v[i]   = '0;
      end
      #23;
      for (int i = 0; i < N; i++) begin
         check_val($sformatf("rst_busy_%0d", i),  130'(busy_v[i]),  130'(0));
         check_val($sformatf("rst_done_%0d", i),  130'(done_v[i]),  130'(0));
         check_val($sformatf("rst_dout_%0d", i),  dout_v[i],        130'(0));
         check_val($sformatf("rst_sclk_%0d", i),  130'(sclk_v[i]),  130'(0));
         check_val($sformatf("rst_sdin_%0d", i),  130'(sdin_v[i]),  130'(0));
         check_val($sformatf("rst_sload_%0d", i), 130'(sload_v[i]), 130'(0));
      end
      @(posedge clk); #1;
      rst = 1'b0;

      // Loopback of 8'hA5 at DIV=2.
      mode_v[0] = 1;
      launch(0, 130'hA5);
      finish_xfer(0, 130'hA5, 130'hA5);

      // DIV=1, sr_dout tied high, all-zero write.
      mode_v[1] = 2;
      launch(1, 130'h0);
      finish_xfer(1, 130'h0, 130'hFF);

      // Extra start pulses at E0+5 and E0+20 must be ignored.
      mode_v[0] = 0;
      pre_v[0]  = rand130();
      w         = rand130();
      launch(0, w);
      repeat (4) @(posedge clk);
      #1 start_v[0] = 1'b1;
      @(posedge clk); #1 start_v[0] = 1'b0;
      repeat (14) @(posedge clk);
      #1 start_v[0] = 1'b1;
      @(posedge clk); #1 start_v[0] = 1'b0;
      finish_xfer(0, w, pre_v[0]);

      // Start coincident with done launches the next transfer.
      mode_v[1] = 0;
      pre_v[1]  = rand130();
      w         = rand130();
      launch(1, w);
      wait_done(1, ok);
      t1 = cyc;
      check_val("coinc_first_out", dout_v[1], pre_v[1] & mask_of(1));
      w2         = rand130();
      p2         = rand130();
      pre_v[1]   = p2;
      din_v[1]   = w2;
      start_v[1] = 1'b1;
      @(posedge clk); #1;
      start_v[1] = 1'b0;
      din_v[1]   = rand130();
      e0_v[1]    = cyc;
      check_val("coinc_busy", 130'(busy_v[1]), 130'(1));
      finish_xfer(1, w2, p2);
      check_val("done_sep", 130'(done_last_v[1] - t1), 130'(lat_of(1) + 1));

      // Asynchronous reset in the high phase of bit 4.
      mode_v[0] = 1;
      launch(0, 130'hFF);
      n = 0;
      while (rises_v[0] < 5 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check_val("rst_reach_bit4", 130'(rises_v[0]), 130'(5));
      #2;
      check_val("pre_rst_sclk", 130'(sclk_v[0]), 130'(1));
      check_val("pre_rst_sdin", 130'(sdin_v[0]), 130'(1));
      rst = 1'b1;
      #1;
      check_val("mid_rst_sclk",  130'(sclk_v[0]),  130'(0));
      check_val("mid_rst_sdin",  130'(sdin_v[0]),  130'(0));
      check_val("mid_rst_busy",  130'(busy_v[0]),  130'(0));
      check_val("mid_rst_sload", 130'(sload_v[0]), 130'(0));
      check_val("mid_rst_done",  130'(done_v[0]),  130'(0));
      check_val("mid_rst_dout",  dout_v[0],        130'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         check_val("post_rst_done", 130'(done_v[0]), 130'(0));
      end
      w = rand130();
      launch(0, w);
      finish_xfer(0, w, w);

      // Random words through the chip model on every instance.
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < N; i++) begin
            mode_v[i] = 0;
            pre_v[i]  = rand130();
            w         = rand130();
            launch(i, w);
            finish_xfer(i, w, pre_v[i]);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
